uart_baud_ctrl: RTL and testbench

- Owns the `prescale` value that drives `baud_rate_generator`.
- Applies a new prescale from software (valid/ready) or from auto-baud measurement of the start bit on `rx_in`.
- Commits a change only when TX and RX are both idle, and pulses `gen_en` low for one cycle so the generator re-phases.
- Sits between the register/config interface and `baud_rate_generator` in the UART top.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_sync2.sv | 13 +
 rtl/uart_baud_ctrl.sv | 91 +++++++++
 tb/tb_uart_baud_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, baud-control state encoding and synchronizer reset value
package uart_pkg;
    localparam int PRESCALE_W       = 8;
    localparam int DEFAULT_PRESCALE = 4;
    localparam logic SYNC_RST_VAL   = 1'b1;
    typedef enum logic [2:0] {
        IDLE,
        WAIT_QUIET,
        APPLY,
        AB_WAIT_HIGH,
        AB_WAIT_FALL,
        AB_MEASURE
    } state_t;
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous single-bit input
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] ff_q;
    always_ff @(posedge clk) ff_q <= rst ? {2{RST_VAL}} : {ff_q[0], d_i};
    assign q_o = ff_q[1];
endmodule

// File: rtl/uart_baud_ctrl.sv
// uart_baud_ctrl: owns the baud prescale, applies software or auto-baud values when the line is quiet
module uart_baud_ctrl #(
    parameter int PRESCALE_W       = uart_pkg::PRESCALE_W,
    parameter int DEFAULT_PRESCALE = uart_pkg::DEFAULT_PRESCALE,
    parameter int CNT_W            = 16,
    parameter int DIV_SHIFT        = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    input  logic [PRESCALE_W-1:0] cfg_prescale,
    output logic                  cfg_ready,
    input  logic                  auto_start,
    input  logic                  rx_in,
    input  logic                  tx_busy,
    input  logic                  rx_busy,
    output logic [PRESCALE_W-1:0] prescale,
    output logic                  gen_en,
    output logic                  auto_done,
    output logic                  err
);
    import uart_pkg::*;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] RES_MAX = CNT_W'({PRESCALE_W{1'b1}});
    state_t                state_q;
    logic [PRESCALE_W-1:0] prescale_q, pending_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d, result;
    logic                  from_ab_q, err_q, auto_done_q, rxs, ab_fail;
    uart_sync2 #(.RST_VAL(SYNC_RST_VAL)) u_sync (.clk(clk), .rst(rst), .d_i(rx_in), .q_o(rxs));
    always_comb begin
        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        result  = cnt_q >> DIV_SHIFT;
        ab_fail = (cnt_q == CNT_MAX) || (result == '0) || (result > RES_MAX);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            prescale_q  <= PRESCALE_W'(DEFAULT_PRESCALE);
            pending_q   <= '0;
            cnt_q       <= '0;
            from_ab_q   <= 1'b0;
            err_q       <= 1'b0;
            auto_done_q <= 1'b0;
        end else begin
            err_q       <= 1'b0;
            auto_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cfg_valid) begin
                        if (cfg_prescale == '0) err_q <= 1'b1;
                        else begin
                            pending_q <= cfg_prescale;
                            from_ab_q <= 1'b0;
                            state_q   <= WAIT_QUIET;
                        end
                    end else if (auto_start) state_q <= AB_WAIT_HIGH;
                end
                WAIT_QUIET: if (!tx_busy && !rx_busy) state_q <= APPLY;
                APPLY: begin
                    prescale_q  <= pending_q;
                    auto_done_q <= from_ab_q;
                    state_q     <= IDLE;
                end
                AB_WAIT_HIGH: if (rxs) state_q <= AB_WAIT_FALL;
                AB_WAIT_FALL: begin
                    if (!rxs) begin
                        cnt_q   <= CNT_W'(1);
                        state_q <= AB_MEASURE;
                    end
                end
                AB_MEASURE: begin
                    if (!rxs) cnt_q <= cnt_d;
                    else if (ab_fail) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        pending_q <= result[PRESCALE_W-1:0];
                        from_ab_q <= 1'b1;
                        state_q   <= WAIT_QUIET;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign prescale  = prescale_q;
    assign gen_en    = state_q != APPLY;
    assign cfg_ready = state_q == IDLE;
    assign auto_done = auto_done_q;
    assign err       = err_q;
endmodule

// File: tb/tb_uart_baud_ctrl.sv
// tb_uart_baud_ctrl: table-driven and directed checks of the baud prescale controller
module tb_uart_baud_ctrl;
    logic       clk = 1'b0, rst = 1'b1, cfg_valid = 1'b0, auto_start = 1'b0;
    logic       rx_in = 1'b1, tx_busy = 1'b0, rx_busy = 1'b0;
    logic [7:0] cfg_prescale = 8'd0;
    logic [7:0] prescale;
    logic       cfg_ready, gen_en, auto_done, err;
    int         tests = 0, fails = 0;
    int         n_ad, n_err, n_gl;
    always #5 clk = ~clk;
    uart_baud_ctrl dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_prescale(cfg_prescale),
        .cfg_ready(cfg_ready), .auto_start(auto_start), .rx_in(rx_in), .tx_busy(tx_busy),
        .rx_busy(rx_busy), .prescale(prescale), .gen_en(gen_en), .auto_done(auto_done), .err(err)
    );
    typedef struct {
        logic       cv;
        logic [7:0] cp;
        logic       as;
        logic       tb;
        logic       rb;
        logic [7:0] e_ps;
        logic       e_gen;
        logic       e_rdy;
        logic       e_err;
        logic       e_ad;
    } vec_t;
    vec_t vecs[14];
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic window(input int n, output int ad, output int er, output int gl);
        ad = 0;
        er = 0;
        gl = 0;
        for (int i = 0; i < n; i++) begin
            step();
            ad += int'(auto_done);
            er += int'(err);
            gl += int'(!gen_en);
            if (auto_done && err) begin
                tests++;
                fails++;
                $display("FAIL done_err_overlap: got 1 expected 0");
            end
        end
    endtask
    task automatic auto_pulse(input int low_cycles);
        rx_in = 1'b1;
        auto_start = 1'b1;
        step();
        auto_start = 1'b0;
        rx_in = 1'b0;
        for (int i = 0; i < low_cycles; i++) step();
        rx_in = 1'b1;
    endtask
    initial begin
        vecs[0]  = '{1'b1, 8'd10, 1'b0, 1'b0, 1'b0, 8'd4,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd4,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd10, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 8'd0,  1'b0, 1'b0, 1'b0, 8'd10, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd10, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 8'd7,  1'b0, 1'b1, 1'b0, 8'd10, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 8'd99, 1'b0, 1'b1, 1'b0, 8'd10, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 8'd10, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd10, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd7,  1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 8'd12, 1'b1, 1'b0, 1'b0, 8'd7,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd7,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd12, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd12, 1'b1, 1'b1, 1'b0, 1'b0};
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_prescale", prescale, 4);
        chk("rst_gen_en", gen_en, 1);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_err", err, 0);
        chk("rst_auto_done", auto_done, 0);
        for (int i = 0; i < 14; i++) begin
            cfg_valid = vecs[i].cv;
            cfg_prescale = vecs[i].cp;
            auto_start = vecs[i].as;
            tx_busy = vecs[i].tb;
            rx_busy = vecs[i].rb;
            step();
            chk($sformatf("vec%0d_prescale", i), prescale, vecs[i].e_ps);
            chk($sformatf("vec%0d_gen_en", i), gen_en, vecs[i].e_gen);
            chk($sformatf("vec%0d_cfg_ready", i), cfg_ready, vecs[i].e_rdy);
            chk($sformatf("vec%0d_err", i), err, vecs[i].e_err);
            chk($sformatf("vec%0d_auto_done", i), auto_done, vecs[i].e_ad);
        end
        cfg_valid = 1'b0;
        auto_start = 1'b0;
        tx_busy = 1'b1;
        cfg_valid = 1'b1;
        cfg_prescale = 8'd20;
        step();
        cfg_valid = 1'b0;
        n_gl = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (prescale != 8'd12 || cfg_ready || !gen_en) n_gl++;
        end
        chk("busy_hold_violations", n_gl, 0);
        tx_busy = 1'b0;
        step();
        chk("busy_apply_gen_en", gen_en, 0);
        chk("busy_apply_prescale", prescale, 12);
        step();
        chk("busy_commit_prescale", prescale, 20);
        chk("busy_commit_gen_en", gen_en, 1);
        auto_pulse(160);
        window(20, n_ad, n_err, n_gl);
        chk("ab160_prescale", prescale, 10);
        chk("ab160_auto_done_pulses", n_ad, 1);
        chk("ab160_gen_low_cycles", n_gl, 1);
        chk("ab160_err_pulses", n_err, 0);
        chk("ab160_cfg_ready", cfg_ready, 1);
        auto_pulse(8);
        window(20, n_ad, n_err, n_gl);
        chk("ab8_err_pulses", n_err, 1);
        chk("ab8_auto_done_pulses", n_ad, 0);
        chk("ab8_gen_low_cycles", n_gl, 0);
        chk("ab8_prescale", prescale, 10);
        auto_pulse(4200);
        window(20, n_ad, n_err, n_gl);
        chk("ab_ovf_err_pulses", n_err, 1);
        chk("ab_ovf_prescale", prescale, 10);
        auto_pulse(4080);
        window(20, n_ad, n_err, n_gl);
        chk("ab4080_prescale", prescale, 255);
        chk("ab4080_auto_done_pulses", n_ad, 1);
        rx_in = 1'b1;
        auto_start = 1'b1;
        step();
        auto_start = 1'b0;
        rx_in = 1'b0;
        repeat (40) step();
        chk("ab_measure_cfg_ready", cfg_ready, 0);
        rst = 1'b1;
        rx_in = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_prescale", prescale, 4);
        chk("midrst_gen_en", gen_en, 1);
        chk("midrst_cfg_ready", cfg_ready, 1);
        window(10, n_ad, n_err, n_gl);
        chk("midrst_quiet_events", n_ad + n_err + n_gl, 0);
        chk("midrst_prescale_later", prescale, 4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
